// File: rtl/uart_rx_ctrl_gen.sv
// UART receive controller: frame FSM, edge/bit counters and per-frame configuration capture.
// Defining UART_RX_BREAK_DET_EN adds break detection with a break_det pulse output.
module uart_rx_ctrl_gen #(
   parameter int MAX_DATA_W = 9,
   parameter int PRESCALE_W = 6,
   parameter int BIT_CNT_W  = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic [3:0]            data_len,
   input  logic                  PAR_EN,
   input  logic                  stop_two,
   input  logic                  strt_glitch,
   input  logic                  par_err,
   input  logic                  stp_err,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic [BIT_CNT_W-1:0]  bit_cnt,
   output logic                  dat_samp_en,
   output logic                  deser_en,
   output logic                  strt_chk_en,
   output logic                  par_chk_en,
   output logic                  stp_chk_en,
   output logic                  data_valid,
   output logic                  frame_err,
`ifdef UART_RX_BREAK_DET_EN
   output logic                  break_det,
`endif
   output logic                  par_err_o
);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, VALID} state_t;

   state_t                state, state_nxt;
   logic [PRESCALE_W-1:0] cfg_p;
   logic [3:0]            cfg_d;
   logic                  cfg_par, cfg_two;
   logic                  dec_edge, data_last, rx_block, frame_start;
   logic [BIT_CNT_W-1:0]  last_idx;

   function automatic logic [PRESCALE_W-1:0] clamp_prescale(input logic [PRESCALE_W-1:0] p);
      if (p == PRESCALE_W'(16) || p == PRESCALE_W'(32)) return p;
      return PRESCALE_W'(8);
   endfunction

   function automatic logic [3:0] clamp_len(input logic [3:0] d);
      if (d < 4'd5) return 4'd5;
      if (d > 4'(MAX_DATA_W)) return 4'(MAX_DATA_W);
      return d;
   endfunction

   assign dec_edge    = (edge_cnt == cfg_p - PRESCALE_W'(1));
   assign data_last   = (bit_cnt == BIT_CNT_W'(cfg_d));
   assign last_idx    = BIT_CNT_W'(cfg_d) + BIT_CNT_W'(cfg_par) + BIT_CNT_W'(cfg_two) + BIT_CNT_W'(1);
   assign frame_start = (state == IDLE || state == VALID) && (state_nxt == START);

`ifdef UART_RX_BREAK_DET_EN
   logic                  brk_flag, brk_hold, brk_now;
   logic [PRESCALE_W-1:0] hold_cnt;
   logic [BIT_CNT_W-1:0]  first_stop_idx;

   assign first_stop_idx = BIT_CNT_W'(cfg_d) + BIT_CNT_W'(cfg_par) + BIT_CNT_W'(1);
   // The current stop-bit sample only counts towards a break on the first stop bit.
   assign brk_now  = brk_flag && (!RX_IN || bit_cnt != first_stop_idx);
   assign rx_block = brk_hold;
`else
   assign rx_block = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      dat_samp_en = 1'b0;
      deser_en    = 1'b0;
      strt_chk_en = 1'b0;
      par_chk_en  = 1'b0;
      stp_chk_en  = 1'b0;
      data_valid  = 1'b0;
      frame_err   = 1'b0;
      par_err_o   = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      break_det   = 1'b0;
`endif
      case (state)
         IDLE: begin
            // RST gate keeps the start strobes low while reset holds the FSM here.
            if (RST && !RX_IN && !rx_block) begin
               state_nxt   = START;
               dat_samp_en = 1'b1;
               strt_chk_en = 1'b1;
            end
         end
         START: begin
            dat_samp_en = 1'b1;
            strt_chk_en = 1'b1;
            if (dec_edge) begin
               if (strt_glitch) begin
                  state_nxt = IDLE;
                  frame_err = 1'b1;
               end else begin
                  state_nxt = DATA;
               end
            end
         end
         DATA: begin
            dat_samp_en = 1'b1;
            deser_en    = 1'b1;
            if (dec_edge && data_last) state_nxt = cfg_par ? PAR : STOP;
         end
         PAR: begin
            dat_samp_en = 1'b1;
            par_chk_en  = 1'b1;
            if (dec_edge) begin
               if (par_err) begin
                  state_nxt = IDLE;
                  par_err_o = 1'b1;
               end else begin
                  state_nxt = STOP;
               end
            end
         end
         STOP: begin
            dat_samp_en = 1'b1;
            stp_chk_en  = 1'b1;
            if (dec_edge) begin
               if (stp_err) begin
                  state_nxt = IDLE;
`ifdef UART_RX_BREAK_DET_EN
                  if (brk_now) break_det = 1'b1;
                  else         frame_err = 1'b1;
`else
                  frame_err = 1'b1;
`endif
               end else if (bit_cnt == last_idx) begin
                  state_nxt = VALID;
               end
            end
         end
         VALID: begin
            data_valid = 1'b1;
            state_nxt  = RX_IN ? IDLE : START;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= IDLE;
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt == IDLE || state_nxt == VALID) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
         end else if (state == IDLE || state == VALID) begin
            // The cycle that saw the falling edge was edge 0 of the start bit.
            edge_cnt <= PRESCALE_W'(1);
            bit_cnt  <= '0;
         end else if (dec_edge) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
         end else begin
            edge_cnt <= edge_cnt + PRESCALE_W'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (frame_start) begin
         cfg_p   <= clamp_prescale(prescale);
         cfg_d   <= clamp_len(data_len);
         cfg_par <= PAR_EN;
         cfg_two <= stop_two;
      end
   end

`ifdef UART_RX_BREAK_DET_EN
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         brk_flag <= 1'b0;
         brk_hold <= 1'b0;
         hold_cnt <= '0;
      end else begin
         if (frame_start)
            brk_flag <= 1'b1;
         else if (state != IDLE && state != VALID && dec_edge && RX_IN && bit_cnt <= first_stop_idx)
            brk_flag <= 1'b0;
         if (break_det) begin
            brk_hold <= 1'b1;
            hold_cnt <= '0;
         end else if (brk_hold) begin
            if (!RX_IN) begin
               hold_cnt <= '0;
            end else if (hold_cnt == cfg_p - PRESCALE_W'(1)) begin
               brk_hold <= 1'b0;
               hold_cnt <= '0;
            end else begin
               hold_cnt <= hold_cnt + PRESCALE_W'(1);
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl_gen.sv
// Testbench for uart_rx_ctrl_gen: randomized frames, frame-level reference model, event scoreboard.
module tb_uart_rx_ctrl_gen;
   localparam int PW = 6;
   localparam int BW = 4;

   logic          CLK = 1'b0, RST = 1'b1, RX_IN = 1'b1;
   logic [PW-1:0] prescale = 8;
   logic [3:0]    data_len = 8;
   logic          PAR_EN = 1'b0, stop_two = 1'b0;
   logic          strt_glitch = 1'b0, par_err = 1'b0, stp_err = 1'b0;
   logic [PW-1:0] edge_cnt;
   logic [BW-1:0] bit_cnt;
   logic          dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
   logic          data_valid, frame_err, par_err_o;

   int   total = 0, bad = 0, cyc = 0;
   bit   mon_on = 1'b0, chk_on = 1'b0;
   logic [14:0] exp_vec = '0;

   typedef struct {int kind; int cyc;} ev_t;   // kind: 1 data_valid, 2 frame_err, 3 par_err_o
   ev_t exp_q[$];

   uart_rx_ctrl_gen #(.MAX_DATA_W(9), .PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
      .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .prescale(prescale), .data_len(data_len),
      .PAR_EN(PAR_EN), .stop_two(stop_two), .strt_glitch(strt_glitch), .par_err(par_err),
      .stp_err(stp_err), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
      .deser_en(deser_en), .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
      .stp_chk_en(stp_chk_en), .data_valid(data_valid), .frame_err(frame_err),
      .par_err_o(par_err_o)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic [14:0] got_vec();
      return {dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, edge_cnt, bit_cnt};
   endfunction

   function automatic logic [17:0] got_all();
      return {got_vec(), data_valid, frame_err, par_err_o};
   endfunction

   // Monitor: per-cycle strobe/counter check plus scoreboard for result pulses.
   always @(negedge CLK) begin
      if (mon_on) begin
         if (chk_on) begin
            total++;
            if (got_vec() !== exp_vec) begin
               bad++;
               $display("FAIL ctrl cyc=%0d got=%h exp=%h", cyc, got_vec(), exp_vec);
            end
         end
         if (data_valid || frame_err || par_err_o) begin
            int k;
            ev_t e;
            k = (32'(data_valid) + 32'(frame_err) + 32'(par_err_o) > 1) ? 9 :
                data_valid ? 1 : (frame_err ? 2 : 3);
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL pulse cyc=%0d got kind=%0d exp none", cyc, k);
            end else begin
               e = exp_q.pop_front();
               if (e.kind != k || e.cyc != cyc) begin
                  bad++;
                  $display("FAIL pulse got kind=%0d cyc=%0d exp kind=%0d cyc=%0d", k, cyc, e.kind, e.cyc);
               end
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic rand_side();
      strt_glitch = 1'($urandom);
      par_err     = 1'($urandom);
      stp_err     = 1'($urandom);
   endtask

   task automatic rand_cfg();
      prescale = PW'($urandom_range(0, 63));
      data_len = 4'($urandom_range(0, 15));
      PAR_EN   = 1'($urandom);
      stop_two = 1'($urandom);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         next_cycle();
         RX_IN   = 1'b1;
         rand_side();
         rand_cfg();
         exp_vec = '0;
      end
   endtask

   // ek: 0 none, 1 start glitch, 2 parity error, 3 error on first stop bit, 4 error on last stop bit
   task automatic run_frame(input int p, input int dl, input bit par, input bit two,
                            input logic [8:0] data, input int ek, input bit in_valid, output bit ok);
      int   pc, dc, last, eb, nbits, b;
      logic bits [16];
      ev_t  e;
      pc   = (p == 16 || p == 32) ? p : 8;
      dc   = (dl < 5) ? 5 : ((dl > 9) ? 9 : dl);
      last = dc + 32'(par) + 32'(two) + 1;
      for (int i = 0; i < 16; i++) bits[i] = 1'b1;
      bits[0] = 1'b0;
      for (int i = 1; i <= dc; i++) bits[i] = data[i-1];
      if (par) begin
         logic px;
         px = 1'b0;
         for (int i = 0; i < dc; i++) px = px ^ data[i];
         bits[dc+1] = px;
      end
      eb = -1;
      case (ek)
         1: eb = 0;
         2: if (par) eb = dc + 1;
         3: eb = dc + 32'(par) + 1;
         4: eb = last;
         default: eb = -1;
      endcase
      nbits = (eb >= 0) ? eb + 1 : last + 1;
      ok = (eb < 0);
      for (int c = 0; c < nbits * pc; c++) begin
         next_cycle();
         b = c / pc;
         if (c == 0) begin
            prescale = PW'(p);
            data_len = 4'(dl);
            PAR_EN   = par;
            stop_two = two;
            if (eb < 0) begin
               e.kind = 1;
               e.cyc  = cyc + nbits * pc;
            end else begin
               e.kind = (par && eb == dc + 1) ? 3 : 2;
               e.cyc  = cyc + nbits * pc - 1;
            end
            exp_q.push_back(e);
         end else begin
            rand_cfg();
         end
         RX_IN = bits[b];
         rand_side();
         if (c % pc == pc - 1) begin
            if (b == 0)                    strt_glitch = (b == eb);
            else if (par && b == dc + 1)   par_err     = (b == eb);
            else if (b > dc)               stp_err     = (b == eb);
         end
         if (c == 0 && in_valid)
            exp_vec = '0;
         else
            exp_vec = {1'b1, (b >= 1 && b <= dc), (b == 0), (par && b == dc + 1),
                       (b > dc + 32'(par)), PW'(c % pc), BW'(b)};
      end
   endtask

   task automatic reset_mid();
      chk_on = 1'b0;
      next_cycle();
      prescale = 8; data_len = 8; PAR_EN = 1'b0; stop_two = 1'b0;
      RX_IN = 1'b0; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
      for (int c = 1; c < 34; c++) begin
         next_cycle();
         RX_IN = (c >= 8) ? c[3] : 1'b0;
      end
      #2;
      RST   = 1'b0;
      RX_IN = 1'b0;
      #1;
      total++;
      if (got_all() !== '0) begin
         bad++;
         $display("FAIL rst_mid got=%h exp=0", got_all());
      end
      repeat (2) @(posedge CLK);
      #3;
      RST     = 1'b1;
      RX_IN   = 1'b1;
      exp_vec = '0;
      chk_on  = 1'b1;
   endtask

   initial begin
      bit ok, prev_ok;
      int p, ek;
      RX_IN = 1'b0;
      #1 RST = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      total++;
      if (got_all() !== '0) begin
         bad++;
         $display("FAIL reset got=%h exp=0", got_all());
      end
      @(posedge CLK);
      #3;
      RST = 1'b1; RX_IN = 1'b1; exp_vec = '0; mon_on = 1'b1; chk_on = 1'b1;
      idle(3);

      run_frame(8, 8, 0, 0, 9'h0A5, 0, 0, ok);  idle(4);
      run_frame(16, 7, 1, 0, 9'h05A, 2, 0, ok); idle(3);
      run_frame(32, 5, 0, 1, 9'h015, 0, 0, ok); idle(2);
      run_frame(32, 5, 0, 1, 9'h00A, 4, 0, ok); idle(2);
      run_frame(8, 8, 0, 0, 9'h03C, 0, 0, ok);
      run_frame(8, 8, 0, 0, 9'h0C3, 0, 1, ok);  idle(3);
      run_frame(8, 8, 0, 0, 9'h055, 0, 0, ok);  idle(1);
      run_frame(8, 6, 0, 0, 9'h02A, 0, 0, ok);  idle(2);
      run_frame(12, 8, 0, 0, 9'h0F0, 0, 0, ok); idle(2);
      run_frame(16, 3, 1, 1, 9'h013, 0, 0, ok); idle(2);
      run_frame(8, 15, 1, 0, 9'h1A7, 0, 0, ok); idle(2);
      run_frame(8, 8, 0, 0, 9'h000, 1, 0, ok);  idle(2);
      run_frame(16, 6, 1, 0, 9'h033, 3, 0, ok); idle(3);
      reset_mid();
      idle(3);
      run_frame(8, 8, 0, 0, 9'h0A5, 0, 0, ok);  idle(2);

      prev_ok = 1'b0;
      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 3))
            0:       p = 8;
            1:       p = 16;
            2:       p = 32;
            default: p = $urandom_range(0, 63);
         endcase
         ek = $urandom_range(0, 7);
         if (ek > 4) ek = 0;
         if (prev_ok && $urandom_range(0, 1) == 1) begin
            run_frame(p, $urandom_range(0, 15), 1'($urandom), 1'($urandom),
                      9'($urandom), ek, 1, ok);
         end else begin
            idle(prev_ok ? $urandom_range(1, 4) : $urandom_range(0, 3));
            run_frame(p, $urandom_range(0, 15), 1'($urandom), 1'($urandom),
                      9'($urandom), ek, 0, ok);
         end
         prev_ok = ok;
      end
      idle(5);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL pending got=%0d exp=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
